// File: rtl/eip_arbiter_pkg.sv
// Shared definitions for the machine external-interrupt arbiter:
// MMIO word addresses, FSM state encoding and claim ID width.
package eip_arbiter_pkg;

   localparam int ID_W = 5;

   localparam logic [1:0] ADDR_PENDING  = 2'd0;
   localparam logic [1:0] ADDR_ENABLE   = 2'd1;
   localparam logic [1:0] ADDR_CLAIM    = 2'd2;
   localparam logic [1:0] ADDR_COMPLETE = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ASSERT   = 2'b01,
      HANDLING = 2'b10
   } state_t;

endpackage : eip_arbiter_pkg

// File: rtl/eip_arbiter_prio_enc.sv
// Fixed-priority encoder: returns lowest set index + 1, or 0 when the
// input vector is empty.
module prio_enc
   import eip_arbiter_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]    vec,
   output logic [ID_W-1:0] id
);

   // Scan from the top so the lowest set bit is the last to overwrite id.
   always_comb begin
      id = '0;
      for (int i = N - 1; i >= 0; i--) begin
         id = vec[i] ? ID_W'(i + 1) : id;
      end
   end

endmodule : prio_enc

// File: rtl/eip_arbiter.sv
// Latches peripheral interrupt pulses, raises m_eip for the highest-priority
// enabled source and tracks claim/complete handshakes with the M-mode handler.
module eip_arbiter
   import eip_arbiter_pkg::*;
#(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_in,
   input  logic [1:0]      a,
   input  logic [31:0]     d,
   input  logic            we,
   output logic [31:0]     spo,
   output logic            m_eip,
   input  logic            m_eip_reply
);

   state_t          state;
   state_t          state_next;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] pending_next;
   logic [NSRC-1:0] enable;
   logic [NSRC-1:0] enable_next;
   logic [ID_W-1:0] claim;
   logic [ID_W-1:0] claim_next;
   logic            m_eip_next;
   logic [ID_W-1:0] sel;
   logic [NSRC-1:0] active;
   logic [NSRC-1:0] w1c_mask;
   logic [NSRC-1:0] claim_mask;
   logic            take_claim;
   logic            wr_pending;
   logic            wr_enable;
   logic            wr_complete;
   logic            unused_ok;

   assign wr_pending  = we && (a == ADDR_PENDING);
   assign wr_enable   = we && (a == ADDR_ENABLE);
   assign wr_complete = we && (a == ADDR_COMPLETE);
   assign active      = pending & enable;
   assign unused_ok   = ^{1'b0, d[31:NSRC]};

   prio_enc #(
      .N (NSRC)
   ) u_prio_enc (
      .vec (active),
      .id  (sel)
   );

   // State register and all architectural registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pending <= '0;
         enable  <= '0;
         claim   <= '0;
         m_eip   <= 1'b0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
         enable  <= enable_next;
         claim   <= claim_next;
         m_eip   <= m_eip_next;
      end
   end

   // Next-state, claim capture and m_eip request decode.
   always_comb begin
      state_next = state;
      claim_next = claim;
      take_claim = 1'b0;
      case (state)
         IDLE: begin
            if (sel != '0) begin
               state_next = ASSERT;
            end else begin
               state_next = IDLE;
            end
         end
         ASSERT: begin
            if (m_eip_reply) begin
               if (sel != '0) begin
                  claim_next = sel;
                  take_claim = 1'b1;
                  state_next = HANDLING;
               end else begin
                  claim_next = '0;
                  state_next = IDLE;
               end
            end else if (sel == '0) begin
               state_next = IDLE;
            end else begin
               state_next = ASSERT;
            end
         end
         HANDLING: begin
            if (wr_complete) begin
               claim_next = '0;
               state_next = IDLE;
            end else begin
               state_next = HANDLING;
            end
         end
         default: begin
            claim_next = '0;
            state_next = IDLE;
         end
      endcase
      m_eip_next = (state_next == ASSERT);
   end

   // Clear masks; a new request in the same cycle always overrides them.
   always_comb begin
      w1c_mask   = '0;
      claim_mask = '0;
      if (wr_pending) begin
         w1c_mask = d[NSRC-1:0];
      end else begin
         w1c_mask = '0;
      end
      for (int i = 0; i < NSRC; i++) begin
         claim_mask[i] = take_claim && (sel == ID_W'(i + 1));
      end
      pending_next = (pending & ~w1c_mask & ~claim_mask) | irq_in;
   end

   // Enable register write port.
   always_comb begin
      enable_next = enable;
      if (wr_enable) begin
         enable_next = d[NSRC-1:0];
      end else begin
         enable_next = enable;
      end
   end

   // Side-effect-free MMIO read mux.
   always_comb begin
      spo = 32'h0000_0000;
      case (a)
         ADDR_PENDING:  spo = 32'(pending);
         ADDR_ENABLE:   spo = 32'(enable);
         ADDR_CLAIM:    spo = {27'd0, claim};
         ADDR_COMPLETE: spo = 32'h0000_0000;
         default:       spo = 32'h0000_0000;
      endcase
   end

endmodule : eip_arbiter
